// File: rtl/shift_pkg.sv
// shift_pkg: FSM state and shift-mode encodings shared by the sequential right shifter
package shift_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
   typedef enum logic [1:0] {MODE_LOGIC = 2'd0, MODE_ARITH = 2'd1, MODE_ROT = 2'd2} mode_t;
endpackage

// File: rtl/shr_step.sv
// shr_step: one-position right shift with an injected fill bit
module shr_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] in,
   input  logic         fill,
   output logic [W-1:0] out
);
   assign out = {fill, in[W-1:1]};
endmodule

// File: rtl/seq_shift_right.sv
// seq_shift_right: multi-cycle logical/arithmetic right shifter, one bit per clock; rotate mode under SEQ_SHIFT_ROTATE_EN
module seq_shift_right
   import shift_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         arith,
`ifdef SEQ_SHIFT_ROTATE_EN
   input  logic         rot,
`endif
   output logic         busy,
   output logic         done,
   output logic [W-1:0] C
);
   localparam int CW = $clog2(W) + 1;
   localparam logic [W-1:0] W_B = W[W-1:0];
   localparam logic [CW-1:0] W_N = W[CW-1:0];
   state_t state, state_nx;
   mode_t mode, mode_nx, mode_in;
   logic [W-1:0] work, work_nx, step;
   logic [CW-1:0] cnt, cnt_nx, n_in;
   logic fill;
`ifdef SEQ_SHIFT_ROTATE_EN
   assign mode_in = rot ? MODE_ROT : arith ? MODE_ARITH : MODE_LOGIC;
`else
   assign mode_in = arith ? MODE_ARITH : MODE_LOGIC;
`endif
   // rotate wraps the amount modulo W; shifts saturate at W
   assign n_in = mode_in == MODE_ROT ? {1'b0, B[CW-2:0]} : B >= W_B ? W_N : B[CW-1:0];
   // the sign bit never changes during an arithmetic shift, so work[W-1] is the latched A[W-1]
   assign fill = mode == MODE_ROT ? work[0] : mode == MODE_ARITH && work[W-1];
   assign busy = state != IDLE;
   assign done = state == DONE;
   shr_step #(.W(W)) u_step (.in(work), .fill(fill), .out(step));
   // next-state, counter and work-register update
   always_comb begin
      state_nx = state;
      mode_nx  = mode;
      work_nx  = work;
      cnt_nx   = cnt;
      case (state)
         IDLE: if (start) begin
            mode_nx  = mode_in;
            work_nx  = A;
            cnt_nx   = n_in;
            state_nx = n_in != '0 ? SHIFT : DONE;
         end
         SHIFT: begin
            work_nx  = step;
            cnt_nx   = cnt - 1'b1;
            state_nx = cnt == CW'(1) ? DONE : SHIFT;
         end
         default: state_nx = IDLE;
      endcase
   end
   // state registers; C captures the final work value only on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mode  <= MODE_LOGIC;
         work  <= '0;
         cnt   <= '0;
         C     <= '0;
      end else begin
         state <= state_nx;
         mode  <= mode_nx;
         work  <= work_nx;
         cnt   <= cnt_nx;
         if (state_nx == DONE) C <= work_nx;
      end
   end
endmodule

// File: tb/tb_seq_shift_right.sv
// tb_seq_shift_right: directed self-checking bench for seq_shift_right (W=8); covers rotate when SEQ_SHIFT_ROTATE_EN is defined
module tb_seq_shift_right;
   logic clk = 1'b0;
   logic rst, start, arith;
   logic [7:0] A, B, C;
   logic busy, done;
`ifdef SEQ_SHIFT_ROTATE_EN
   logic rot;
`endif
   int checks = 0;
   int failures = 0;
   logic [7:0] last_c;

   seq_shift_right #(.W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .arith(arith),
`ifdef SEQ_SHIFT_ROTATE_EN
      .rot(rot),
`endif
      .busy(busy), .done(done), .C(C)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ar,
                      input logic ro, input logic [7:0] exp_c, input int exp_lat);
      int lat;
      @(negedge clk);
      start = 1'b1; A = a; B = b; arith = ar;
`ifdef SEQ_SHIFT_ROTATE_EN
      rot = ro;
`endif
      edge1();
      start = 1'b0; A = ~a; B = 8'h01; arith = ~ar;
`ifdef SEQ_SHIFT_ROTATE_EN
      rot = 1'b0;
`endif
      chk({tag, "_busy1"}, busy, 1'b1);
      if (exp_lat > 1) chk({tag, "_c_hold"}, C, last_c);
      lat = 1;
      while (!done && lat < 20) begin
         edge1();
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_c"}, C, exp_c);
      last_c = exp_c;
      edge1();
      chk({tag, "_idle"}, {busy, done}, 2'b00);
      chk({tag, "_c_keep"}, C, exp_c);
      if (ro) chk({tag, "_ro"}, ro, 1'b1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; A = '0; B = '0; arith = 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
      rot = 1'b0;
`endif
      last_c = 8'h00;
      repeat (2) edge1();
      chk("reset_state", {busy, done, C}, 10'h000);
      @(negedge clk);
      rst = 1'b0;

      run("t1_lsr2",   8'hB4, 8'd2,   1'b0, 1'b0, 8'h2D, 3);
      run("t2_asr2",   8'hB4, 8'd2,   1'b1, 1'b0, 8'hED, 3);
      run("t3_zero",   8'h5A, 8'd0,   1'b0, 1'b0, 8'h5A, 1);
      run("t4_lsr_f8", 8'h80, 8'hF8,  1'b0, 1'b0, 8'h00, 9);
      run("t4_asr_f8", 8'h80, 8'hF8,  1'b1, 1'b0, 8'hFF, 9);
      run("asr3",      8'h96, 8'd3,   1'b1, 1'b0, 8'hF2, 4);
      run("asr7_pos",  8'h7F, 8'd7,   1'b1, 1'b0, 8'h00, 8);
      run("lsr7",      8'h80, 8'd7,   1'b0, 1'b0, 8'h01, 8);
      run("lsr8",      8'hFF, 8'd8,   1'b0, 1'b0, 8'h00, 9);

      // start pulses while busy must be ignored
      @(negedge clk);
      start = 1'b1; A = 8'hF0; B = 8'd4; arith = 1'b0;
      edge1();
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; A = 8'h00; B = 8'd0; arith = 1'b1;
      edge1();
      start = 1'b0;
      chk("busy_start_busy", busy, 1'b1);
      chk("busy_start_c", C, 8'h00);
      repeat (2) edge1();
      chk("busy_start_nodone", done, 1'b0);
      edge1();
      chk("busy_start_done", {done, C}, 9'h10F);
      edge1();
      chk("busy_start_after", {busy, done, C}, 10'h00F);

      // reset mid-shift discards the operation
      @(negedge clk);
      start = 1'b1; A = 8'hFF; B = 8'd5; arith = 1'b1;
      edge1();
      start = 1'b0;
      edge1();
      chk("rst_mid_busy_pre", busy, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      edge1();
      chk("rst_mid_state", {busy, done, C}, 10'h000);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) edge1();
      chk("rst_mid_quiet", {busy, done, C}, 10'h000);

      // reset and start together stay idle
      run("pre_rs", 8'h3C, 8'd1, 1'b0, 1'b0, 8'h1E, 2);
      @(negedge clk);
      rst = 1'b1; start = 1'b1; A = 8'h11; B = 8'd0;
      edge1();
      chk("rst_start_idle", {busy, done, C}, 10'h000);
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      edge1();
      chk("rst_start_after", {busy, done, C}, 10'h000);
      last_c = 8'h00;

`ifdef SEQ_SHIFT_ROTATE_EN
      run("rot9",      8'h81, 8'd9,  1'b0, 1'b1, 8'hC0, 2);
      run("rot_mult8", 8'hA5, 8'd16, 1'b1, 1'b1, 8'hA5, 1);
      run("rot3",      8'h0F, 8'd3,  1'b1, 1'b1, 8'hE1, 4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
